// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states,
// word-organised array, valid/ready request and response channels.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_write_byte,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  // 33 bits so a window ending at 4 GiB does not wrap to zero
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     addr_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            resp_valid_q;
  logic [31:0]     resp_rdata_q;
  logic            resp_err_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     offset_d;
  logic [AW-1:0]   word_idx_d;
  logic            acc_err_d;
  logic            wr_en_d;

  assign offset_d   = addr_q - BASE_ADDR;
  assign word_idx_d = AW'(offset_d >> 2);
  assign acc_err_d  = (addr_q < BASE_ADDR) ||
                      ({1'b0, addr_q} >= END_ADDR) ||
                      (addr_q[1:0] != 2'b00);
  assign wr_en_d    = (state_q == S_ACCESS) && !acc_err_d && (be_q != 4'b0000);

  assign req_ready  = (state_q == S_IDLE) && reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Array is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[word_idx_d][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            be_q    <= req_write_byte;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == WAIT_LAST) begin
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Reads return the pre-write word; writes and errors return zero
          if (acc_err_d || (be_q != 4'b0000)) begin
            resp_rdata_q <= '0;
          end else begin
            resp_rdata_q <= mem[word_idx_d];
          end
          resp_err_q   <= acc_err_d;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) driven by directed vectors;
// expectations are queued at issue and checked by per-instance response monitors.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic [3:0]  req_be     [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_write_byte(req_be[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_write_byte(req_be[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic void mon(int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_checks++;
      $display("FAIL resp%0d_unexpected: got response rdata=%h with no expectation queued", d, resp_rdata[d]);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    $display("resp dut%0d rdata=%h err=%b (want %h/%b)", d, resp_rdata[d], resp_err[d], e.rdata, e.err);
    check($sformatf("resp%0d_rdata", d), resp_rdata[d], e.rdata);
    check($sformatf("resp%0d_err", d), {31'b0, resp_err[d]}, {31'b0, e.err});
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    always @(negedge clk) begin
      if (rst_n && resp_valid[gi] && resp_ready[gi]) mon(gi);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int d, logic [31:0] rd, logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic do_req(int d, logic [31:0] addr, logic [3:0] be, logic [31:0] wd,
                        logic [31:0] exp_rd, logic exp_err, int exp_lat, bit handshake);
    int n;
    int lat;
    n = 0;
    while (!req_ready[d] && n < 50) begin tick(); n++; end
    if (!req_ready[d]) begin
      n_checks++;
      $display("FAIL req_ready_timeout dut%0d: got req_ready=0 after 50 cycles, expected 1", d);
      return;
    end
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    req_be[d]    = be;
    req_wdata[d] = wd;
    push(d, exp_rd, exp_err);
    tick();
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 50) begin tick(); lat++; end
    check($sformatf("latency%0d_%h", d, addr), 32'(lat), 32'(exp_lat));
    if (handshake && resp_ready[d]) begin
      tick();
      check($sformatf("req_ready_after_hs%0d", d), {31'b0, req_ready[d]}, 32'd1);
    end
  endtask

  task automatic b2b(bit rd);
    int acc[3];
    int n;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr[1]  = 32'h100 + 32'(4 * k);
      req_be[1]    = rd ? 4'b0000 : 4'b1111;
      req_wdata[1] = 32'hA000_0000 + 32'(k);
      push(1, rd ? 32'hA000_0000 + 32'(k) : 32'h0, 1'b0);
      n = 0;
      while (!req_ready[1] && n < 20) begin tick(); n++; end
      acc[k] = cyc;
      tick();
    end
    req_valid[1] = 1'b0;
    check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd3);
    check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd3);
    repeat (4) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      req_addr[d]   = '0;
      req_be[d]     = '0;
      req_wdata[d]  = '0;
      resp_ready[d] = 1'b1;
    end
    #12;
    check("rst_req_ready", {31'b0, req_ready[0]}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("rst_resp_rdata", resp_rdata[0], 32'd0);
    check("rst_resp_err", {31'b0, resp_err[0]}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", {31'b0, req_ready[0]}, 32'd1);

    // Write/read, partial write, errors, last word (2 wait states)
    do_req(0, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b1);
    do_req(0, 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
    do_req(0, 32'h10, 4'b0101, 32'h11223344, 32'h0, 1'b0, 3, 1'b1);
    do_req(0, 32'h10, 4'b0000, 32'h0, 32'hDE22BE44, 1'b0, 3, 1'b1);
    do_req(0, 32'h1000, 4'b0000, 32'h0, 32'h0, 1'b1, 3, 1'b1);
    do_req(0, 32'h12, 4'b1111, 32'hFFFFFFFF, 32'h0, 1'b1, 3, 1'b1);
    do_req(0, 32'h10, 4'b0000, 32'h0, 32'hDE22BE44, 1'b0, 3, 1'b1);
    do_req(0, 32'hFFC, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 3, 1'b1);
    do_req(0, 32'hFFC, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1);

    // Back-pressure: response must hold for 5 cycles
    resp_ready[0] = 1'b0;
    do_req(0, 32'h10, 4'b0000, 32'h0, 32'hDE22BE44, 1'b0, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'b0, resp_valid[0]}, 32'd1);
      check("bp_rdata", resp_rdata[0], 32'hDE22BE44);
      check("bp_err", {31'b0, resp_err[0]}, 32'd0);
      check("bp_req_ready", {31'b0, req_ready[0]}, 32'd0);
    end
    resp_ready[0] = 1'b1;
    tick();
    check("bp_valid_after_hs", {31'b0, resp_valid[0]}, 32'd0);
    check("bp_req_ready_after_hs", {31'b0, req_ready[0]}, 32'd1);

    // Reset in the middle of a write's wait states: no write may land
    do_req(0, 32'h20, 4'b1111, 32'h0, 32'h0, 1'b0, 3, 1'b1);
    req_valid[0] = 1'b1; req_addr[0] = 32'h20; req_be[0] = 4'b1111; req_wdata[0] = 32'h55AA55AA;
    tick();
    req_valid[0] = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_wait_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("arst_wait_req_ready", {31'b0, req_ready[0]}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    do_req(0, 32'h20, 4'b0000, 32'h0, 32'h0, 1'b0, 3, 1'b1);

    // Reset while a response is being held clears it without a clock edge
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_addr[0] = 32'h10; req_be[0] = 4'b0000;
    tick();
    req_valid[0] = 1'b0;
    tick(); tick(); tick();
    check("arst_resp_pre_valid", {31'b0, resp_valid[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("arst_resp_rdata", resp_rdata[0], 32'd0);
    tick();
    rst_n = 1'b1;
    resp_ready[0] = 1'b1;

    // Zero wait states: single-cycle latency and 3-clock back-to-back spacing
    do_req(1, 32'h40, 4'b1111, 32'h01020304, 32'h0, 1'b0, 1, 1'b1);
    do_req(1, 32'h40, 4'b0000, 32'h0, 32'h01020304, 1'b0, 1, 1'b1);
    b2b(1'b0);
    b2b(1'b1);

    repeat (5) tick();
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1, "timeout");
  end

endmodule
